// File: rtl/regs_dump_reader.sv
// regs_dump_reader: walks an 8x32 dual-read-port register file one pair per fetch
// and streams the mask-selected words over a valid/ready interface.
module regs_dump_reader (
  input  logic        clk,
  input  logic        cr,
  input  logic        start,
  input  logic [7:0]  mask,
  output logic [2:0]  Addr_A,
  output logic [2:0]  Addr_B,
  input  logic [31:0] QA,
  input  logic [31:0] QB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN_A, DRAIN_B, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  p_q, p_d;
  logic [7:0]  m_q, m_d;
  logic [31:0] bufa_q, bufa_d, bufb_q, bufb_d;
  logic        bit_a, bit_b, xfer;
  assign Addr_A = {p_q, 1'b0};
  assign Addr_B = {p_q, 1'b1};
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  always_comb begin
    out_valid = state_q == DRAIN_A || state_q == DRAIN_B;
    out_idx   = out_valid ? {p_q, state_q == DRAIN_B} : 3'd0;
    out_data  = state_q == DRAIN_A ? bufa_q : state_q == DRAIN_B ? bufb_q : 32'd0;
    // last word: no selected register above the one being presented
    out_last  = out_valid && ((m_q >> out_idx) >> 1) == 8'd0;
    bit_a     = m_q[{p_q, 1'b0}];
    bit_b     = m_q[{p_q, 1'b1}];
    xfer      = out_valid && out_ready;
    bufa_d    = state_q == FETCH ? QA : bufa_q;
    bufb_d    = state_q == FETCH ? QB : bufb_q;
  end
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    case (state_q)
      IDLE: if (start) begin
        m_d     = mask;
        p_d     = 2'd0;
        state_d = mask != 8'd0 ? FETCH : DONE;
      end
      FETCH: begin
        if (bit_a) state_d = DRAIN_A;
        else if (bit_b) state_d = DRAIN_B;
        else if (p_q == 2'd3) state_d = DONE;
        else p_d = p_q + 2'd1;
      end
      DRAIN_A: if (xfer) begin
        if (bit_b) state_d = DRAIN_B;
        else if (out_last) state_d = DONE;
        else begin
          state_d = FETCH;
          p_d     = p_q + 2'd1;
        end
      end
      DRAIN_B: if (xfer) begin
        if (out_last) state_d = DONE;
        else begin
          state_d = FETCH;
          p_d     = p_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state_q <= IDLE;
      p_q     <= 2'd0;
      m_q     <= 8'd0;
      bufa_q  <= 32'd0;
      bufb_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      bufa_q  <= bufa_d;
      bufb_q  <= bufb_d;
    end
  end
endmodule

// File: tb/tb_regs_dump_reader.sv
// tb_regs_dump_reader: directed scenarios against hand-derived cycle timings of the dump engine.
module tb_regs_dump_reader;
  logic        clk = 1'b0;
  logic        cr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic [2:0]  Addr_A, Addr_B;
  logic [31:0] QA, QB;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last, busy, done;
  logic [31:0] rf [8];
  int vec_cnt = 0;
  int err_cnt = 0;
  int          w_n, done_n, done_cyc, busy_n, busy_last, st_n;
  int          w_idx [16];
  logic [31:0] w_dat [16];
  logic        w_last [16];
  int          w_cyc [16];
  int          st_idx [16];
  logic [31:0] st_dat [16];
  logic        st_last [16];

  always #5 clk = ~clk;
  assign QA = rf[Addr_A];
  assign QB = rf[Addr_B];

  regs_dump_reader dut (
    .clk(clk), .cr(cr), .start(start), .mask(mask),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .QA(QA), .QB(QB),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  // start sampled at edge T0; mask is scrambled afterwards to prove it was latched
  task automatic do_start(input logic [7:0] mk);
    @(negedge clk);
    start = 1'b1;
    mask  = mk;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = 8'h00;
  endtask

  // records cycle k = 1..maxc after T0; stalls the first 'stall' valid cycles,
  // re-pulses start during cycles sp1/sp2
  task automatic capture(input int maxc, input int stall, input int sp1, input int sp2);
    w_n = 0; done_n = 0; done_cyc = -1; busy_n = 0; busy_last = -1; st_n = 0;
    for (int i = 0; i < 16; i++) begin
      w_idx[i] = -1; w_dat[i] = '0; w_last[i] = 1'b0; w_cyc[i] = -1;
      st_idx[i] = -1; st_dat[i] = '0; st_last[i] = 1'b0;
    end
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = (k == sp1 || k == sp2);
      if (out_valid && st_n < stall) begin
        out_ready = 1'b0;
        if (st_n < 16) begin
          st_idx[st_n] = int'(out_idx); st_dat[st_n] = out_data; st_last[st_n] = out_last;
        end
        st_n++;
      end else out_ready = 1'b1;
      if (out_valid && out_ready) begin
        if (w_n < 16) begin
          w_idx[w_n] = int'(out_idx); w_dat[w_n] = out_data;
          w_last[w_n] = out_last; w_cyc[w_n] = k;
        end
        w_n++;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (busy) begin
        busy_n++;
        busy_last = k;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    vec_cnt++; if (Addr_A !== 3'd0) begin err_cnt++; $display("FAIL rst_addr_a got %0d want 0", Addr_A); end
    vec_cnt++; if (Addr_B !== 3'd1) begin err_cnt++; $display("FAIL rst_addr_b got %0d want 1", Addr_B); end
    vec_cnt++; if (out_data !== 32'd0) begin err_cnt++; $display("FAIL rst_data got %0h want 0", out_data); end
    vec_cnt++; if ({out_idx, out_last, busy, done} !== 6'd0) begin err_cnt++; $display("FAIL rst_misc got %b want 000000", {out_idx, out_last, busy, done}); end
    @(negedge clk);
    @(negedge clk);
    cr = 1'b1;
    @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_full_dump;
    int exp_cyc [8] = '{2, 3, 5, 6, 8, 9, 11, 12};
    do_start(8'hFF);
    capture(20, 0, 0, 0);
    vec_cnt++; if (w_n !== 8) begin err_cnt++; $display("FAIL full_count got %0d want 8", w_n); end
    for (int i = 0; i < 8; i++) begin
      vec_cnt++; if (w_idx[i] !== i) begin err_cnt++; $display("FAIL full_idx[%0d] got %0d want %0d", i, w_idx[i], i); end
      vec_cnt++; if (w_dat[i] !== 32'h1000_0000 + i) begin err_cnt++; $display("FAIL full_data[%0d] got %0h want %0h", i, w_dat[i], 32'h1000_0000 + i); end
      vec_cnt++; if (w_cyc[i] !== exp_cyc[i]) begin err_cnt++; $display("FAIL full_cycle[%0d] got %0d want %0d", i, w_cyc[i], exp_cyc[i]); end
      vec_cnt++; if (w_last[i] !== (i == 7)) begin err_cnt++; $display("FAIL full_last[%0d] got %0b want %0b", i, w_last[i], i == 7); end
    end
    vec_cnt++; if (done_cyc !== 13) begin err_cnt++; $display("FAIL full_done_cycle got %0d want 13", done_cyc); end
    vec_cnt++; if (done_n !== 1) begin err_cnt++; $display("FAIL full_done_count got %0d want 1", done_n); end
    vec_cnt++; if (busy_n !== 13) begin err_cnt++; $display("FAIL full_busy_cycles got %0d want 13", busy_n); end
    vec_cnt++; if (busy_last !== 13) begin err_cnt++; $display("FAIL full_busy_last got %0d want 13", busy_last); end
  endtask

  task automatic test_sparse;
    do_start(8'h81);
    capture(12, 0, 0, 0);
    vec_cnt++; if (w_n !== 2) begin err_cnt++; $display("FAIL sparse_count got %0d want 2", w_n); end
    vec_cnt++; if (w_idx[0] !== 0 || w_idx[1] !== 7) begin err_cnt++; $display("FAIL sparse_idx got %0d,%0d want 0,7", w_idx[0], w_idx[1]); end
    vec_cnt++; if (w_dat[1] !== 32'h1000_0007) begin err_cnt++; $display("FAIL sparse_data got %0h want 10000007", w_dat[1]); end
    vec_cnt++; if (w_cyc[0] !== 2 || w_cyc[1] !== 6) begin err_cnt++; $display("FAIL sparse_cycles got %0d,%0d want 2,6", w_cyc[0], w_cyc[1]); end
    vec_cnt++; if (w_last[0] !== 1'b0 || w_last[1] !== 1'b1) begin err_cnt++; $display("FAIL sparse_last got %0b,%0b want 0,1", w_last[0], w_last[1]); end
    vec_cnt++; if (done_cyc !== 7 || done_n !== 1) begin err_cnt++; $display("FAIL sparse_done got cyc %0d n %0d want cyc 7 n 1", done_cyc, done_n); end
  endtask

  task automatic test_zero_mask;
    do_start(8'h00);
    capture(6, 0, 0, 0);
    vec_cnt++; if (w_n !== 0) begin err_cnt++; $display("FAIL zero_words got %0d want 0", w_n); end
    vec_cnt++; if (done_cyc !== 1 || done_n !== 1) begin err_cnt++; $display("FAIL zero_done got cyc %0d n %0d want cyc 1 n 1", done_cyc, done_n); end
    vec_cnt++; if (busy_n !== 1 || busy_last !== 1) begin err_cnt++; $display("FAIL zero_busy got n %0d last %0d want n 1 last 1", busy_n, busy_last); end
  endtask

  task automatic test_backpressure;
    do_start(8'h0C);
    capture(14, 5, 0, 0);
    vec_cnt++; if (st_n !== 5) begin err_cnt++; $display("FAIL bp_stall_cycles got %0d want 5", st_n); end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (st_idx[i] !== 2 || st_dat[i] !== 32'h1000_0002 || st_last[i] !== 1'b0) begin
        err_cnt++; $display("FAIL bp_hold[%0d] got idx %0d data %0h last %0b want idx 2 data 10000002 last 0", i, st_idx[i], st_dat[i], st_last[i]);
      end
    end
    vec_cnt++; if (w_n !== 2) begin err_cnt++; $display("FAIL bp_count got %0d want 2", w_n); end
    vec_cnt++; if (w_idx[0] !== 2 || w_idx[1] !== 3) begin err_cnt++; $display("FAIL bp_idx got %0d,%0d want 2,3", w_idx[0], w_idx[1]); end
    vec_cnt++; if (w_cyc[0] !== 8 || w_cyc[1] !== 9) begin err_cnt++; $display("FAIL bp_cycles got %0d,%0d want 8,9", w_cyc[0], w_cyc[1]); end
    vec_cnt++; if (w_last[1] !== 1'b1 || w_dat[1] !== 32'h1000_0003) begin err_cnt++; $display("FAIL bp_last got last %0b data %0h want 1 10000003", w_last[1], w_dat[1]); end
    vec_cnt++; if (done_cyc !== 10) begin err_cnt++; $display("FAIL bp_done got %0d want 10", done_cyc); end
  endtask

  task automatic test_start_ignored;
    do_start(8'hFF);
    capture(25, 0, 4, 13);
    vec_cnt++; if (w_n !== 8) begin err_cnt++; $display("FAIL ign_count got %0d want 8", w_n); end
    vec_cnt++; if (done_n !== 1 || done_cyc !== 13) begin err_cnt++; $display("FAIL ign_done got n %0d cyc %0d want n 1 cyc 13", done_n, done_cyc); end
    vec_cnt++; if (w_idx[7] !== 7 || w_cyc[7] !== 12) begin err_cnt++; $display("FAIL ign_last_word got idx %0d cyc %0d want 7 12", w_idx[7], w_cyc[7]); end
    vec_cnt++; if (busy_last !== 13) begin err_cnt++; $display("FAIL ign_busy_last got %0d want 13", busy_last); end
  endtask

  task automatic test_reset_mid;
    do_start(8'hFF);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin err_cnt++; $display("FAIL mid_pre got valid %0b idx %0d want 1 3", out_valid, out_idx); end
    cr = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ctl got valid %0b busy %0b done %0b want 0 0 0", out_valid, busy, done); end
    vec_cnt++; if (Addr_A !== 3'd0 || Addr_B !== 3'd1) begin err_cnt++; $display("FAIL mid_rst_addr got %0d,%0d want 0,1", Addr_A, Addr_B); end
    vec_cnt++; if (out_data !== 32'd0 || out_idx !== 3'd0 || out_last !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_out got data %0h idx %0d last %0b want 0 0 0", out_data, out_idx, out_last); end
    @(negedge clk);
    cr = 1'b1;
    rf[1] = 32'h2000_0001;
    do_start(8'h02);
    capture(8, 0, 0, 0);
    vec_cnt++; if (w_n !== 1) begin err_cnt++; $display("FAIL mid_count got %0d want 1", w_n); end
    vec_cnt++; if (w_idx[0] !== 1 || w_dat[0] !== 32'h2000_0001 || w_last[0] !== 1'b1) begin err_cnt++; $display("FAIL mid_word got idx %0d data %0h last %0b want 1 20000001 1", w_idx[0], w_dat[0], w_last[0]); end
    vec_cnt++; if (w_cyc[0] !== 2 || done_cyc !== 3) begin err_cnt++; $display("FAIL mid_timing got word %0d done %0d want 2 3", w_cyc[0], done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 32'h1000_0000 + i;
    test_reset;
    test_full_dump;
    test_sparse;
    test_zero_mask;
    test_backpressure;
    test_start_ignored;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
